team_06_ptt_link_arbiter: RTL

//  Half-duplex arbiter for the shared 8-bit audio sample path. Grants it to transmit (mic -> tx)
//  on push-to-talk or to receive (rx -> speaker) on detected carrier. Enforces listen-before-talk,

---
 rtl/team_06_ptt_link_arbiter_if.sv | 27 ++
 rtl/team_06_ptt_link_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/team_06_ptt_link_arbiter_if.sv
// Sample-path bundle for the PTT link arbiter: key levels, mic/rx sample
// strobes in, arbitration state and tx/speaker sample strobes out.
interface team_06_ptt_link_arbiter_if;
   logic       ptt;
   logic       mute;
   logic       mic_valid;
   logic [7:0] mic_sample;
   logic       rx_valid;
   logic [7:0] rx_sample;
   logic [1:0] state;
   logic       tx_valid;
   logic [7:0] tx_sample;
   logic       spk_valid;
   logic [7:0] spk_sample;
   logic       busy;
   logic       tx_timeout;

   modport master (
      output ptt, mute, mic_valid, mic_sample, rx_valid, rx_sample,
      input  state, tx_valid, tx_sample, spk_valid, spk_sample, busy, tx_timeout
   );

   modport slave (
      input  ptt, mute, mic_valid, mic_sample, rx_valid, rx_sample,
      output state, tx_valid, tx_sample, spk_valid, spk_sample, busy, tx_timeout
   );
endinterface

// File: rtl/team_06_ptt_link_arbiter.sv
// Half-duplex PTT link arbiter: grants the 8-bit sample path to TX (mic) on
// push-to-talk or to RX (speaker) on carrier, with listen-before-talk, RX hang
// time, TX->IDLE guard interval and transmit time-out.
// Optional feature macro: PTT_OVERRIDE_EN (ptt pre-empts RX and wins over
// carrier in IDLE). Undefined: RX is never pre-empted.
module team_06_ptt_link_arbiter #(
   parameter int unsigned SQUELCH_TH   = 8,
   parameter int unsigned HANG_SAMPLES = 64,
   parameter int unsigned GUARD_CYCLES = 32,
   parameter int unsigned TOT_SAMPLES  = 240000
) (
   input logic                         clk,
   input logic                         rst,
   team_06_ptt_link_arbiter_if.slave   bus
);
   localparam int unsigned HANG_W  = $clog2(HANG_SAMPLES + 1);
   localparam int unsigned GUARD_W = $clog2(GUARD_CYCLES + 1);
   localparam int unsigned TOT_W   = $clog2(TOT_SAMPLES + 1);
   localparam logic [HANG_W-1:0] HANG_MAX = HANG_W'(HANG_SAMPLES);
   localparam logic [TOT_W-1:0]  TOT_MAX  = TOT_W'(TOT_SAMPLES);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RX    = 2'b01,
      TX    = 2'b10,
      GUARD = 2'b11
   } state_t;

   state_t               state_q, state_d;
   logic [HANG_W-1:0]    hang_q, hang_d;
   logic [GUARD_W-1:0]   guard_q, guard_d;
   logic [TOT_W-1:0]     tot_q, tot_d, tot_inc;
   logic                 tx_timeout_q, tx_timeout_d;
   logic [8:0]           mag;
   logic                 carrier;
   logic                 ptt_ok;
   logic                 busy_c;
   logic                 tx_valid_q, spk_valid_q;
   logic [7:0]           tx_sample_q, spk_sample_q;

   // Carrier detect: 9-bit distance from midscale so 0x00 yields 128.
   always_comb begin
      mag = '0;
      if (bus.rx_sample[7]) mag = {1'b0, bus.rx_sample} - 9'd128;
      else                  mag = 9'd128 - {1'b0, bus.rx_sample};
      carrier = bus.rx_valid && (32'(mag) > SQUELCH_TH);
      ptt_ok  = bus.ptt && !tx_timeout_q;
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         hang_q       <= '0;
         guard_q      <= '0;
         tot_q        <= '0;
         tx_timeout_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hang_q       <= hang_d;
         guard_q      <= guard_d;
         tot_q        <= tot_d;
         tx_timeout_q <= tx_timeout_d;
      end
   end

   // Next-state and counter updates; all counters saturate.
   always_comb begin
      state_d      = state_q;
      hang_d       = hang_q;
      guard_d      = guard_q;
      tot_d        = tot_q;
      tot_inc      = (tot_q == TOT_MAX) ? tot_q : tot_q + TOT_W'(1);
      tx_timeout_d = bus.ptt ? tx_timeout_q : 1'b0;
      case (state_q)
         IDLE: begin
`ifdef PTT_OVERRIDE_EN
            if (ptt_ok) begin
               state_d = TX;
               tot_d   = '0;
            end else if (carrier) begin
               state_d = RX;
               hang_d  = HANG_MAX;
            end
`else
            if (carrier) begin
               state_d = RX;
               hang_d  = HANG_MAX;
            end else if (ptt_ok) begin
               state_d = TX;
               tot_d   = '0;
            end
`endif
         end
         RX: begin
`ifdef PTT_OVERRIDE_EN
            if (ptt_ok) begin
               state_d = TX;
               hang_d  = '0;
               tot_d   = '0;
            end else
`endif
            if (carrier) begin
               hang_d = HANG_MAX;
            end else if (bus.rx_valid) begin
               // The strobe that exhausts the hang count also leaves RX.
               if (hang_q <= HANG_W'(1)) begin
                  hang_d  = '0;
                  state_d = IDLE;
               end else begin
                  hang_d = hang_q - HANG_W'(1);
               end
            end
         end
         TX: begin
            if (bus.mic_valid) tot_d = tot_inc;
            if (!bus.ptt) begin
               state_d = GUARD;
               guard_d = '0;
            end else if (bus.mic_valid && (tot_inc == TOT_MAX)) begin
               state_d      = GUARD;
               guard_d      = '0;
               tx_timeout_d = 1'b1;
            end
         end
         default: begin
            if (32'(guard_q) + 32'd1 >= GUARD_CYCLES) begin
               state_d = IDLE;
               guard_d = '0;
            end else begin
               guard_d = guard_q + GUARD_W'(1);
            end
         end
      endcase
   end

   // Status outputs decoded from the current state.
   always_comb begin
      busy_c = (state_q == RX);
   end

   // Sample datapath: one-cycle latency, routed by the state at the strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_valid_q   <= 1'b0;
         tx_sample_q  <= 8'h80;
         spk_valid_q  <= 1'b0;
         spk_sample_q <= 8'h80;
      end else begin
         tx_valid_q <= (state_q == TX) && bus.mic_valid;
         if ((state_q == TX) && bus.mic_valid)
            tx_sample_q <= bus.mute ? 8'h80 : bus.mic_sample;
         case (state_q)
            RX: begin
               spk_valid_q <= bus.rx_valid;
               if (bus.rx_valid) spk_sample_q <= bus.rx_sample;
            end
            IDLE: begin
               spk_valid_q <= bus.rx_valid;
               if (bus.rx_valid) spk_sample_q <= 8'h80;
            end
            default: spk_valid_q <= 1'b0;
         endcase
      end
   end

   assign bus.state      = state_q;
   assign bus.busy       = busy_c;
   assign bus.tx_timeout = tx_timeout_q;
   assign bus.tx_valid   = tx_valid_q;
   assign bus.tx_sample  = tx_sample_q;
   assign bus.spk_valid  = spk_valid_q;
   assign bus.spk_sample = spk_sample_q;
endmodule
